// File: rtl/line_kcpe_pkg.sv
// line_kcpe_pkg: shared FSM state type, pipeline latency and accumulator sizing
// for the line KCPE conv2d array.
package line_kcpe_pkg;

    typedef enum logic [1:0] {IDLE, LOAD_W, RUN} state_t;

    localparam int PIPE_LAT = 3;

    function automatic int acc_width(input int bw, input int nkcpe, input int nch);
        return 2 * bw + $clog2(nkcpe * nch) + 1;
    endfunction

endpackage

// File: rtl/kcpe_dot_unit.sv
// kcpe_dot_unit: one kernel's dot product -- registered products, then a
// registered sum of all products plus the incoming partial sum.
module kcpe_dot_unit
    import line_kcpe_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_PROD   = 9,
    parameter int PSUM_WIDTH = 16,
    parameter int SUM_WIDTH  = 22
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sum_en,
    input  logic [BIT_WIDTH*NUM_PROD-1:0] data,
    input  logic [BIT_WIDTH*NUM_PROD-1:0] weight,
    input  logic [PSUM_WIDTH-1:0]         psum,
    input  logic                          psum_val,
    output logic signed [SUM_WIDTH-1:0]   sum
);

    localparam int MW = 2 * BIT_WIDTH;

    logic signed [MW-1:0]         prod [NUM_PROD];
    logic signed [PSUM_WIDTH-1:0] psum_q;
    logic signed [SUM_WIDTH-1:0]  sum_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PROD; i++) prod[i] <= '0;
            psum_q <= '0;
        end else if (en) begin
            for (int i = 0; i < NUM_PROD; i++)
                prod[i] <= MW'($signed(data[i*BIT_WIDTH +: BIT_WIDTH])) *
                           MW'($signed(weight[i*BIT_WIDTH +: BIT_WIDTH]));
            psum_q <= psum_val ? $signed(psum) : '0;
        end
    end

    always_comb begin
        sum_c = SUM_WIDTH'(psum_q);
        for (int i = 0; i < NUM_PROD; i++) sum_c = sum_c + SUM_WIDTH'(prod[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        sum <= '0;
        else if (sum_en) sum <= sum_c;
    end

endmodule

// File: rtl/line_kcpe_conv2d_array.sv
// line_kcpe_conv2d_array: per-kernel multi-position/multi-channel MAC with weight
// loading FSM and saturating output. Define LINE_KCPE_ERR_MON_EN for error counters.
module line_kcpe_conv2d_array
    import line_kcpe_pkg::*;
#(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int NUM_KCPE    = 3,
    parameter int PSUM_WIDTH  = 16,
    parameter int REG_WIDTH   = 32
)(
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KCPE-1:0]  i_data,
    input  logic                                       i_data_val,
    input  logic [BIT_WIDTH*NUM_KERNEL*NUM_KCPE-1:0]   i_weight,
    input  logic                                       i_weight_val,
    input  logic [PSUM_WIDTH*NUM_KERNEL-1:0]           i_psum,
    input  logic                                       i_psum_val,
    output logic                                       o_ready,
    output logic [PSUM_WIDTH*NUM_KERNEL-1:0]           o_psum,
    output logic [NUM_KERNEL-1:0]                      o_psum_val,
    output logic [REG_WIDTH-1:0]                       err_psum_val,
    output logic [REG_WIDTH-1:0]                       err_data_drop
);

    localparam int NP = NUM_KCPE * NUM_CHANNEL;
    localparam int AW = acc_width(BIT_WIDTH, NUM_KCPE, NUM_CHANNEL);
    localparam int SW = (AW > PSUM_WIDTH ? AW : PSUM_WIDTH) + 1;
    localparam int CW = NUM_CHANNEL > 1 ? $clog2(NUM_CHANNEL) : 1;
    localparam int WB = BIT_WIDTH * NUM_KERNEL * NUM_KCPE;
    localparam int PW = PSUM_WIDTH;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx, wr_ch;
    logic                  wr_en, accept;
    logic [WB-1:0]         w_reg [NUM_CHANNEL];
    logic [PIPE_LAT-1:0]   v;
    logic signed [SW-1:0]  sum [NUM_KERNEL];
    logic [PW-1:0]         sat [NUM_KERNEL];

    // A weight beat always wins over a coincident data beat.
    assign accept  = i_data_val && state == RUN && !i_weight_val;
    assign o_ready = state == RUN;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr_en    = i_weight_val;
        wr_ch    = cnt;
        if (i_weight_val) begin
            if (state == LOAD_W) begin
                cnt_nx   = cnt + CW'(1);
                state_nx = cnt == CW'(NUM_CHANNEL - 1) ? RUN : LOAD_W;
            end else begin
                wr_ch    = '0;
                cnt_nx   = CW'(1);
                state_nx = NUM_CHANNEL == 1 ? RUN : LOAD_W;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            v     <= '0;
            for (int c = 0; c < NUM_CHANNEL; c++) w_reg[c] <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            v     <= {v[PIPE_LAT-2:0], accept};
            for (int c = 0; c < NUM_CHANNEL; c++)
                if (wr_en && wr_ch == CW'(c)) w_reg[c] <= i_weight;
        end
    end

    for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_k
        logic [BIT_WIDTH*NP-1:0] wk;
        // Regroup weights from channel-major storage into the data's p*NUM_CHANNEL+c order.
        for (genvar p = 0; p < NUM_KCPE; p++) begin : g_p
            for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_c
                assign wk[(p*NUM_CHANNEL+c)*BIT_WIDTH +: BIT_WIDTH] =
                    w_reg[c][(k*NUM_KCPE+p)*BIT_WIDTH +: BIT_WIDTH];
            end
        end
        kcpe_dot_unit #(
            .BIT_WIDTH (BIT_WIDTH),
            .NUM_PROD  (NP),
            .PSUM_WIDTH(PW),
            .SUM_WIDTH (SW)
        ) u_dot (
            .clk     (clk),
            .rst     (rst),
            .en      (accept),
            .sum_en  (v[0]),
            .data    (i_data),
            .weight  (wk),
            .psum    (i_psum[k*PW +: PW]),
            .psum_val(i_psum_val),
            .sum     (sum[k])
        );
        assign sat[k] = (&sum[k][SW-1:PW-1] || ~|sum[k][SW-1:PW-1]) ? sum[k][PW-1:0]
                      : {sum[k][SW-1], {(PW-1){~sum[k][SW-1]}}};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      o_psum <= '0;
        else if (v[1]) for (int k = 0; k < NUM_KERNEL; k++) o_psum[k*PW +: PW] <= sat[k];
    end

    assign o_psum_val = {NUM_KERNEL{v[PIPE_LAT-1]}};

`ifdef LINE_KCPE_ERR_MON_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_psum_val  <= '0;
            err_data_drop <= '0;
        end else begin
            if (accept && !i_psum_val && ~&err_psum_val)   err_psum_val  <= err_psum_val + 1'b1;
            if (i_data_val && !accept && ~&err_data_drop) err_data_drop <= err_data_drop + 1'b1;
        end
    end
`else
    assign err_psum_val  = '0;
    assign err_data_drop = '0;
`endif

endmodule

// File: tb/tb_line_kcpe_conv2d_array.sv
// tb_line_kcpe_conv2d_array: directed checks of loading, MAC, saturation,
// drop/error counting, pipeline timing and asynchronous reset.
module tb_line_kcpe_conv2d_array;

`ifdef LINE_KCPE_ERR_MON_EN
    localparam int MON = 1;
`else
    localparam int MON = 0;
`endif

    logic         clk = 0;
    logic         rst = 0;
    logic [71:0]  i_data = '0;
    logic         i_data_val = 0;
    logic [95:0]  i_weight = '0;
    logic         i_weight_val = 0;
    logic [63:0]  i_psum = '0;
    logic         i_psum_val = 0;
    logic         o_ready;
    logic [63:0]  o_psum;
    logic [3:0]   o_psum_val;
    logic [31:0]  err_psum_val;
    logic [31:0]  err_data_drop;

    int n_chk = 0;
    int n_fail = 0;

    line_kcpe_conv2d_array dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_data_val   (i_data_val),
        .i_weight     (i_weight),
        .i_weight_val (i_weight_val),
        .i_psum       (i_psum),
        .i_psum_val   (i_psum_val),
        .o_ready      (o_ready),
        .o_psum       (o_psum),
        .o_psum_val   (o_psum_val),
        .err_psum_val (err_psum_val),
        .err_data_drop(err_data_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_psum(input string tag, input logic [15:0] e);
        for (int k = 0; k < 4; k++) chk(tag, 64'(o_psum[k*16 +: 16]), 64'(e));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [7:0] w);
        i_weight     = {12{w}};
        i_weight_val = 1;
        repeat (3) step();
        i_weight_val = 0;
    endtask

    task automatic set_beat(input logic [7:0] d, input logic [15:0] p, input logic pv);
        i_data     = {9{d}};
        i_psum     = {4{p}};
        i_psum_val = pv;
        i_data_val = 1;
    endtask

    initial begin
        #12;
        chk("rst_ready", 64'(o_ready), 64'(0));
        chk("rst_val", 64'(o_psum_val), 64'(0));
        chk("rst_psum", o_psum, 64'(0));
        chk("rst_err_pv", 64'(err_psum_val), 64'(0));
        chk("rst_err_drop", 64'(err_data_drop), 64'(0));
        rst = 1;
        step();

        // data in IDLE, then in LOAD_W between weight beats
        set_beat(8'd2, 16'd0, 1);
        step();
        i_data_val = 0;
        i_weight = {12{8'd1}};
        i_weight_val = 1;
        step();
        i_weight_val = 0;
        i_data_val = 1;
        step();
        chk("loadw_ready", 64'(o_ready), 64'(0));
        i_data_val = 0;
        i_weight_val = 1;
        repeat (2) step();
        i_weight_val = 0;
        chk("run_ready", 64'(o_ready), 64'(1));
        step();
        chk("drop_no_val", 64'(o_psum_val), 64'(0));
        chk("err_drop2", 64'(err_data_drop), 64'(2 * MON));

        // basic MAC: 9 * 2 * 1 = 18, valid exactly 3 cycles after acceptance
        set_beat(8'd2, 16'd0, 1);
        step();
        i_data_val = 0;
        chk("lat1_val", 64'(o_psum_val), 64'(0));
        step();
        chk("lat2_val", 64'(o_psum_val), 64'(0));
        step();
        chk("lat3_val", 64'(o_psum_val), 64'hf);
        chk_psum("mac18", 16'd18);
        step();
        chk("hold_val", 64'(o_psum_val), 64'(0));
        chk_psum("hold18", 16'd18);

        // positive saturation
        load_w(8'h7f);
        set_beat(8'h7f, 16'h7fff, 1);
        step();
        i_data_val = 0;
        repeat (2) step();
        chk_psum("sat_pos", 16'h7fff);

        // negative saturation
        load_w(8'h80);
        set_beat(8'h7f, 16'h8000, 1);
        step();
        i_data_val = 0;
        repeat (2) step();
        chk_psum("sat_neg", 16'h8000);

        // back-to-back beats then reload: old weights 1 -> 18+5=23, 27
        load_w(8'd1);
        set_beat(8'd2, 16'd5, 1);
        step();
        set_beat(8'd3, 16'd100, 0);
        step();
        i_data_val = 0;
        i_weight = {12{8'd2}};
        i_weight_val = 1;
        step();
        chk("b2b_val1", 64'(o_psum_val), 64'hf);
        chk_psum("b2b_r1", 16'd23);
        step();
        chk("b2b_val2", 64'(o_psum_val), 64'hf);
        chk_psum("b2b_r2", 16'd27);
        step();
        i_weight_val = 0;
        chk("b2b_end_val", 64'(o_psum_val), 64'(0));
        chk("err_pv1", 64'(err_psum_val), 64'(MON));

        // coincident weight and data in RUN: weight wins, data dropped
        i_weight = {12{8'd2}};
        i_weight_val = 1;
        set_beat(8'd5, 16'd0, 1);
        step();
        i_data_val = 0;
        chk("coll_ready", 64'(o_ready), 64'(0));
        repeat (2) step();
        i_weight_val = 0;
        chk("err_drop3", 64'(err_data_drop), 64'(3 * MON));
        set_beat(8'd1, 16'd0, 1);
        step();
        i_data_val = 0;
        chk("coll_no_out", 64'(o_psum_val), 64'(0));
        repeat (2) step();
        chk_psum("new_w18", 16'd18);

        // reset with results in flight
        set_beat(8'd1, 16'd1, 1);
        repeat (3) step();
        i_data_val = 0;
        chk("pre_rst_val", 64'(o_psum_val), 64'hf);
        rst = 0;
        #1;
        chk("async_val", 64'(o_psum_val), 64'(0));
        chk("async_ready", 64'(o_ready), 64'(0));
        chk("async_psum", o_psum, 64'(0));
        step();
        rst = 1;
        repeat (4) begin
            step();
            chk("post_rst_val", 64'(o_psum_val), 64'(0));
        end
        chk("post_rst_ready", 64'(o_ready), 64'(0));
        chk("post_rst_err", 64'(err_data_drop), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
